// File: rtl/serial2parallel.sv
// Serial-to-parallel receiver: captures an N-bit LSB-first frame framed by
// start/end strobes, presents it on q with a one-cycle valid, flags bad frames.
module serial2parallel #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         d,
  input  logic         serial_start,
  input  logic         serial_end,
  output logic [N-1:0] q,
  output logic         valid,
  output logic         err,
  output logic         busy
);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  localparam logic [3:0] LAST = 4'(N - 1);

  state_t         state_q;
  logic   [3:0]   cnt_q;
  logic   [N-1:0] shift_q;
  logic   [N-1:0] shift_d;
  logic   [N-1:0] q_q;
  logic           valid_q;
  logic           err_q;

  // Bits enter at the MSB and drift down; after N captures bit 0 sits at the
  // LSB, so every bit position is overwritten within one frame.
  assign shift_d = {d, shift_q[N-1:1]};

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (serial_start) begin
            shift_q <= shift_d;
            cnt_q   <= 4'd1;
            state_q <= RECV;
          end else if (serial_end) begin
            err_q <= 1'b1;
          end
        end
        RECV: begin
          if (serial_start) begin
            // Restart: the aborted frame is reported, the new one begins now.
            err_q   <= 1'b1;
            shift_q <= shift_d;
            cnt_q   <= 4'd1;
          end else if (cnt_q < LAST) begin
            if (serial_end) begin
              err_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + 4'd1;
            end
          end else begin
            if (serial_end) begin
              q_q     <= shift_d;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q     = q_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = (state_q == RECV);

endmodule

// File: tb/tb_serial2parallel.sv
// Directed, table-driven bench for serial2parallel (N=8): frame vectors with
// expected outputs after each sampling edge, plus a mid-frame reset sequence.
module tb_serial2parallel;

  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic         d;
  logic         serial_start;
  logic         serial_end;
  logic [N-1:0] q;
  logic         valid;
  logic         err;
  logic         busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         s;
    logic         e;
    logic         dd;
    logic [N-1:0] eq;
    logic         ev;
    logic         ee;
    logic         eb;
  } vec_t;

  vec_t tbl[$];

  serial2parallel #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .d            (d),
    .serial_start (serial_start),
    .serial_end   (serial_end),
    .q            (q),
    .valid        (valid),
    .err          (err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [N-1:0] eq, input logic ev,
                            input logic ee, input logic eb);
    check({tag, ".q"},     16'(q),     16'(eq));
    check({tag, ".valid"}, 16'(valid), 16'(ev));
    check({tag, ".err"},   16'(err),   16'(ee));
    check({tag, ".busy"},  16'(busy),  16'(eb));
  endtask

  task automatic add(input logic s, input logic e, input logic dd, input logic [N-1:0] eq,
                     input logic ev, input logic ee, input logic eb);
    vec_t v;
    v.s = s; v.e = e; v.dd = dd; v.eq = eq; v.ev = ev; v.ee = ee; v.eb = eb;
    tbl.push_back(v);
  endtask

  // A complete well-formed frame; first_err marks a frame that restarts another.
  task automatic add_frame(input logic [N-1:0] w, input logic [N-1:0] prior, input logic first_err);
    add(1'b1, 1'b0, w[0], prior, 1'b0, first_err, 1'b1);
    for (int k = 1; k < N - 1; k++) add(1'b0, 1'b0, w[k], prior, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, w[N-1], w, 1'b1, 1'b0, 1'b0);
  endtask

  // The first nbits of a frame, no end strobe, no completion.
  task automatic add_bits(input logic [N-1:0] w, input int nbits, input logic [N-1:0] prior);
    for (int k = 0; k < nbits; k++) add(k == 0, 1'b0, w[k], prior, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic step(input logic s, input logic e, input logic dd);
    serial_start = s;
    serial_end   = e;
    d            = dd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    d            = 1'b0;
    serial_start = 1'b0;
    serial_end   = 1'b0;

    // Idle
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    // Good frame 0xA5, then one idle cycle to see valid drop
    add_frame(8'hA5, 8'h00, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    // Back-to-back 0x3C, 0xFF
    add_frame(8'h3C, 8'hA5, 1'b0);
    add_frame(8'hFF, 8'h3C, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    // Early end on 5th bit of 0x0F
    add_bits(8'h0F, 4, 8'hFF);
    add(1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    // Missing end on 0x81
    add_bits(8'h81, 7, 8'hFF);
    add(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    // Stray end in IDLE
    add(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    // Restart on 4th bit, then a full 0x5A
    add_bits(8'hC3, 3, 8'hFF);
    add_frame(8'h5A, 8'hFF, 1'b1);
    add(1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].e, tbl[i].dd);
      check_outs($sformatf("vec%0d", i), tbl[i].eq, tbl[i].ev, tbl[i].ee, tbl[i].eb);
    end

    // Mid-frame reset: drop frame immediately with no err, resume only on start
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("midrst.busy_before", 16'(busy), 16'd1);
    #2 reset = 1'b0;
    #1;
    check_outs("midrst.async", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    check_outs("midrst.held", 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < N; k++) begin
      step(1'b0, k == N - 1, 1'b1);
      check(  $sformatf("postrst%0d.busy",  k), 16'(busy),  16'd0);
      check(  $sformatf("postrst%0d.valid", k), 16'(valid), 16'd0);
      check(  $sformatf("postrst%0d.q",     k), 16'(q),     16'h00);
      check(  $sformatf("postrst%0d.err",   k), 16'(err),   (k == N - 1) ? 16'd1 : 16'd0);
    end
    // Fresh frame 0x96 after reset
    for (int k = 0; k < N; k++) begin
      logic [N-1:0] w;
      w = 8'h96;
      step(k == 0, k == N - 1, w[k]);
    end
    check_outs("fresh", 8'h96, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
